// File: rtl/reg_select_encode_seq.sv
// Register-file select/encode unit: latches the instruction, decodes Ra/Rb/Rc into
// registered one-hot enables, and produces the extended C constant.
module reg_select_encode_seq #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned SEL_W    = 4,
  parameter int unsigned INSTR_W  = 32,
  parameter int unsigned RA_LSB   = 23,
  parameter int unsigned RB_LSB   = 19,
  parameter int unsigned RC_LSB   = 15,
  parameter int unsigned CONST_W  = 19,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                clock,
  input  logic                clear,
  input  logic [INSTR_W-1:0]  instr_in,
  input  logic                ir_load,
  input  logic                gra,
  input  logic                grb,
  input  logic                grc,
  input  logic                rin,
  input  logic                rout,
  input  logic                baout,
  input  logic                sext,
  output logic [INSTR_W-1:0]  ir_q,
  output logic [NUM_REGS-1:0] r_in,
  output logic [NUM_REGS-1:0] r_out,
  output logic                ba_zero,
  output logic [SEL_W-1:0]    sel_idx,
  output logic [DATA_W-1:0]   c_ext,
  output logic                sel_err
);

  logic                any_gr;
  logic                multi_gr;
  logic                orphan_req;
  logic                sel_is_r0;
  logic [SEL_W-1:0]    sel;
  logic [NUM_REGS-1:0] sel_onehot;
  logic [DATA_W-1:0]   c_zext;
  logic [DATA_W-1:0]   fill_mask;
  logic [DATA_W-1:0]   c_next;

  assign any_gr     = gra | grb | grc;
  assign multi_gr   = (gra & grb) | (gra & grc) | (grb & grc);
  assign orphan_req = (rin | rout | baout) & ~any_gr;
  assign sel_is_r0  = (sel == '0);

  // Field comes from the pre-load ir_q; gra wins over grb, grb over grc.
  always_comb begin
    sel = ir_q[RC_LSB +: SEL_W];
    if (gra) begin
      sel = ir_q[RA_LSB +: SEL_W];
    end else if (grb) begin
      sel = ir_q[RB_LSB +: SEL_W];
    end
    sel_onehot      = '0;
    sel_onehot[sel] = 1'b1;
  end

  // Bits at and above CONST_W; collapses to zero when DATA_W == CONST_W.
  assign fill_mask = ~((DATA_W'(1) << CONST_W) - DATA_W'(1));
  assign c_zext    = DATA_W'(instr_in[CONST_W-1:0]);

  always_comb begin
    c_next = c_zext;
    if (sext && instr_in[CONST_W-1]) begin
      c_next = c_zext | fill_mask;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      ir_q    <= '0;
      r_in    <= '0;
      r_out   <= '0;
      ba_zero <= 1'b0;
      sel_idx <= '0;
      c_ext   <= '0;
      sel_err <= 1'b0;
    end else begin
      if (ir_load) begin
        ir_q  <= instr_in;
        c_ext <= c_next;
      end
      r_in <= (rin && any_gr) ? sel_onehot : '0;
      // A base-address read of R0 drives a zero source instead of R0 itself.
      r_out   <= (any_gr && (rout || baout) && !(baout && sel_is_r0)) ? sel_onehot : '0;
      ba_zero <= baout & any_gr & sel_is_r0;
      if (any_gr) begin
        sel_idx <= sel;
      end
      if (multi_gr || orphan_req) begin
        sel_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_select_encode_seq.sv
// Bench for reg_select_encode_seq: directed vectors, a behavioural model checked every
// cycle, and literal expectations for the documented scenarios.
module tb_reg_select_encode_seq;

  localparam int NUM_REGS = 16;
  localparam int SEL_W    = 4;
  localparam int INSTR_W  = 32;
  localparam int RA_LSB   = 23;
  localparam int RB_LSB   = 19;
  localparam int RC_LSB   = 15;
  localparam int CONST_W  = 19;
  localparam int DATA_W   = 32;

  logic                clock = 1'b0;
  logic                clear = 1'b1;
  logic [INSTR_W-1:0]  instr_in = '0;
  logic                ir_load = 1'b0;
  logic                gra = 1'b0, grb = 1'b0, grc = 1'b0;
  logic                rin = 1'b0, rout = 1'b0, baout = 1'b0;
  logic                sext = 1'b0;
  logic [INSTR_W-1:0]  ir_q;
  logic [NUM_REGS-1:0] r_in;
  logic [NUM_REGS-1:0] r_out;
  logic                ba_zero;
  logic [SEL_W-1:0]    sel_idx;
  logic [DATA_W-1:0]   c_ext;
  logic                sel_err;

  int total = 0;
  int bad   = 0;
  bit armed = 1'b0;

  reg_select_encode_seq dut (
    .clock    (clock),
    .clear    (clear),
    .instr_in (instr_in),
    .ir_load  (ir_load),
    .gra      (gra),
    .grb      (grb),
    .grc      (grc),
    .rin      (rin),
    .rout     (rout),
    .baout    (baout),
    .sext     (sext),
    .ir_q     (ir_q),
    .r_in     (r_in),
    .r_out    (r_out),
    .ba_zero  (ba_zero),
    .sel_idx  (sel_idx),
    .c_ext    (c_ext),
    .sel_err  (sel_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain arithmetic on register numbers.
  longint m_ir = 0;
  longint m_rin = 0, m_rout = 0, m_c = 0;
  int     m_sel = 0;
  bit     m_ba = 0, m_err = 0;
  int     n_gr, fld;
  longint cval;

  always @(posedge clock or posedge clear) begin
    if (clear) begin
      m_ir = 0; m_rin = 0; m_rout = 0; m_c = 0; m_sel = 0; m_ba = 0; m_err = 0;
    end else begin
      n_gr = int'(gra) + int'(grb) + int'(grc);
      if (gra)      fld = int'((m_ir >> RA_LSB) % NUM_REGS);
      else if (grb) fld = int'((m_ir >> RB_LSB) % NUM_REGS);
      else          fld = int'((m_ir >> RC_LSB) % NUM_REGS);
      m_rin  = (n_gr > 0 && rin) ? (longint'(1) << fld) : 0;
      m_rout = (n_gr > 0 && (rout || baout) && !(baout && fld == 0)) ? (longint'(1) << fld) : 0;
      m_ba   = (n_gr > 0) && baout && (fld == 0);
      if (n_gr > 0) m_sel = fld;
      if (n_gr > 1 || (n_gr == 0 && (rin || rout || baout))) m_err = 1;
      if (ir_load) begin
        m_ir = longint'(instr_in);
        cval = m_ir % (longint'(1) << CONST_W);
        if (sext && cval >= (longint'(1) << (CONST_W - 1))) cval = cval - (longint'(1) << CONST_W);
        m_c = cval & ((longint'(1) << DATA_W) - 1);
      end
    end
  end

  always @(negedge clock) begin
    if (armed) begin
      chk("ir_q",    64'(ir_q),    64'(m_ir));
      chk("r_in",    64'(r_in),    64'(m_rin));
      chk("r_out",   64'(r_out),   64'(m_rout));
      chk("ba_zero", 64'(ba_zero), 64'(m_ba));
      chk("sel_idx", 64'(sel_idx), 64'(m_sel));
      chk("c_ext",   64'(c_ext),   64'(m_c));
      chk("sel_err", 64'(sel_err), 64'(m_err));
    end
  end

  // Apply one cycle of stimulus; returns 2 time units after the capturing edge.
  task automatic step(input bit ld, input logic [31:0] ins, input bit sx,
                      input bit a, input bit b, input bit c,
                      input bit wi, input bit wo, input bit bo);
    ir_load = ld; instr_in = ins; sext = sx;
    gra = a; grb = b; grc = c; rin = wi; rout = wo; baout = bo;
    @(posedge clock);
    #2;
  endtask

  task automatic idle();
    step(0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #12 clear = 1'b0;
    armed = 1'b1;

    // 1. Async clear while r_in is asserted.
    step(1, 32'h0200_0000, 0, 0, 0, 0, 0, 0, 0);
    step(0, 32'h0, 0, 1, 0, 0, 1, 0, 0);
    chk("t1_rin_before_clear", 64'(r_in), 64'h0010);
    ir_load = 0; gra = 0; rin = 0;
    #1 clear = 1'b1;
    #1;
    chk("t1_rin_async",   64'(r_in),    64'h0);
    chk("t1_ir_async",    64'(ir_q),    64'h0);
    chk("t1_sel_async",   64'(sel_idx), 64'h0);
    clear = 1'b0;
    idle();

    // 2. Ra write decode.
    step(1, 32'h0118_8000, 0, 0, 0, 0, 0, 0, 0);
    step(0, 32'h0, 0, 1, 0, 0, 1, 0, 0);
    chk("t2_rin",     64'(r_in),    64'h0004);
    chk("t2_sel_idx", 64'(sel_idx), 64'h2);
    chk("t2_sel_err", 64'(sel_err), 64'h0);
    idle();
    chk("t2_rin_drop", 64'(r_in), 64'h0);

    // 3. Rb read, then Rc write decoded from the pre-load instruction.
    step(0, 32'h0, 0, 0, 1, 0, 0, 1, 0);
    chk("t3_rout", 64'(r_out), 64'h0008);
    step(1, 32'h0002_8000, 0, 0, 0, 1, 1, 0, 0);
    chk("t3_rin_old_rc", 64'(r_in), 64'h0002);
    chk("t3_ir_new",     64'(ir_q), 64'h0002_8000);
    step(0, 32'h0, 0, 0, 0, 1, 1, 1, 0);
    chk("t3_rin_new_rc",  64'(r_in),  64'h0020);
    chk("t3_rout_new_rc", 64'(r_out), 64'h0020);
    idle();

    // 4. R0 base-address handling; Ra=6, Rb=0.
    step(1, 32'h0300_0000, 0, 0, 0, 0, 0, 0, 0);
    step(0, 32'h0, 0, 0, 1, 0, 0, 0, 1);
    chk("t4_ba_rout",    64'(r_out),   64'h0);
    chk("t4_ba_zero",    64'(ba_zero), 64'h1);
    step(0, 32'h0, 0, 0, 1, 0, 0, 1, 0);
    chk("t4_r0_rout",    64'(r_out),   64'h0001);
    chk("t4_r0_ba_zero", 64'(ba_zero), 64'h0);
    step(0, 32'h0, 0, 0, 1, 0, 0, 1, 1);
    chk("t4_both_rout",  64'(r_out),   64'h0);
    step(0, 32'h0, 0, 1, 0, 0, 0, 0, 1);
    chk("t4_ba_ra6",     64'(r_out),   64'h0040);
    chk("t4_ba_ra6_bz",  64'(ba_zero), 64'h0);
    idle();

    // 5. Constant extension.
    step(1, 32'h0007_FFFF, 1, 0, 0, 0, 0, 0, 0);
    chk("t5_sext1", 64'(c_ext), 64'hFFFF_FFFF);
    step(1, 32'h0007_FFFF, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_sext0", 64'(c_ext), 64'h0007_FFFF);
    step(1, 32'h0003_FFFF, 1, 0, 0, 0, 0, 0, 0);
    chk("t5_pos",   64'(c_ext), 64'h0003_FFFF);
    step(0, 32'h0007_FFFF, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_hold",  64'(c_ext), 64'h0003_FFFF);

    // 6. Protocol error is sticky until clear.
    step(1, 32'h0238_0000, 0, 0, 0, 0, 0, 0, 0);
    step(0, 32'h0, 0, 1, 1, 0, 1, 0, 0);
    chk("t6_rin",     64'(r_in),    64'h0010);
    chk("t6_sel_err", 64'(sel_err), 64'h1);
    step(0, 32'h0, 0, 0, 1, 0, 1, 0, 0);
    chk("t6_rin_rb",  64'(r_in),    64'h0080);
    idle();
    chk("t6_sticky",  64'(sel_err), 64'h1);
    #1 clear = 1'b1;
    #1 chk("t6_cleared", 64'(sel_err), 64'h0);
    clear = 1'b0;
    idle();
    chk("t6_first_r0", 64'(sel_idx), 64'h0);
    step(0, 32'h0, 0, 0, 0, 0, 1, 0, 0);
    chk("t6_orphan_err", 64'(sel_err), 64'h1);
    chk("t6_orphan_rin", 64'(r_in),    64'h0);
    step(0, 32'h0, 0, 0, 0, 1, 0, 1, 0);
    chk("t6_r0_after_clear", 64'(r_out), 64'h0001);
    idle();
    idle();

    armed = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
